// File: rtl/clip_test.sv
// Point-in-window test: high when (px, py) lies inside the inclusive window.
module clip_test #(
  parameter int unsigned CORDW = 16
) (
  input  logic signed [CORDW-1:0] px,
  input  logic signed [CORDW-1:0] py,
  input  logic signed [CORDW-1:0] cx0,
  input  logic signed [CORDW-1:0] cy0,
  input  logic signed [CORDW-1:0] cx1,
  input  logic signed [CORDW-1:0] cy1,
  output logic                    inside_c
);

  assign inside_c = (px >= cx0) && (px <= cx1) && (py >= cy0) && (py <= cy1);

endmodule

// File: rtl/line_stream.sv
// Bresenham line rasteriser with clip window, dash pattern and a valid/ready
// pixel stream; endpoints are ordered so y only ever increases.
module line_stream #(
  parameter int unsigned CORDW = 16,
  parameter int unsigned PATW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  input  logic signed [CORDW-1:0] cx0,
  input  logic signed [CORDW-1:0] cy0,
  input  logic signed [CORDW-1:0] cx1,
  input  logic signed [CORDW-1:0] cy1,
  input  logic [PATW-1:0]         pattern,
  input  logic                    out_ready,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    out_valid,
  output logic                    last,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned W1   = CORDW + 1;
  localparam int unsigned W2   = CORDW + 2;
  localparam int unsigned IDXW = (PATW > 1) ? $clog2(PATW) : 1;

  typedef enum logic [1:0] {IDLE, INIT_0, INIT_1, DRAW} state_t;

  state_t state, state_next;

  logic signed [CORDW-1:0] xa_q, ya_q, xb_q, yb_q;
  logic signed [CORDW-1:0] cx0_q, cy0_q, cx1_q, cy1_q;
  logic [PATW-1:0]         pat_q;
  logic                    x_dec_q;
  logic signed [W1-1:0]    dx_q, dy_q, err_q;
  logic [IDXW-1:0]         idx_q;

  logic                    in_win_c, visible_c, at_end_c, step_en_c;
  logic [IDXW-1:0]         idx_next_c;
  logic signed [W1-1:0]    xdiff_c, err_next_c;
  logic signed [W2-1:0]    e2_c;
  logic                    x_step_c, y_step_c;

  clip_test #(.CORDW(CORDW)) u_clip (
    .px      (x),
    .py      (y),
    .cx0     (cx0_q),
    .cy0     (cy0_q),
    .cx1     (cx1_q),
    .cy1     (cy1_q),
    .inside_c(in_win_c)
  );

  assign visible_c  = in_win_c && pat_q[idx_q];
  assign at_end_c   = (x == xb_q) && (y == yb_q);
  assign idx_next_c = (PATW == 1) ? '0 : idx_q + IDXW'(1);
  assign xdiff_c    = W1'(xb_q) - W1'(xa_q);

  assign out_valid = (state == DRAW) && visible_c;
  assign last      = (state == DRAW) && at_end_c;
  assign busy      = (state != IDLE);

  // Bresenham decision, with 2*err widened so full-scale spans cannot overflow
  always_comb begin
    e2_c       = W2'(err_q) <<< 1;
    x_step_c   = (e2_c >= W2'(dy_q));
    y_step_c   = (e2_c < W2'(dx_q));
    err_next_c = err_q;
    if (x_step_c) err_next_c = err_next_c + dy_q;
    if (y_step_c) err_next_c = err_next_c + dx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Invisible pixels step freely; visible ones wait for the consumer
  always_comb begin
    state_next = state;
    step_en_c  = 1'b0;
    case (state)
      IDLE:   if (start) state_next = INIT_0;
      INIT_0: state_next = INIT_1;
      INIT_1: state_next = DRAW;
      DRAW: begin
        if (y > cy1_q) begin
          state_next = IDLE;
        end else if (!visible_c || out_ready) begin
          if (at_end_c) state_next = IDLE;
          else          step_en_c  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == DRAW) && (state_next == IDLE);
      if (state == IDLE && start) idx_q <= '0;
      else if (step_en_c)         idx_q <= idx_next_c;
    end
  end

  // Datapath: latch request, derive deltas, then walk the line
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          if (y1 < y0) begin
            xa_q <= x1; ya_q <= y1; xb_q <= x0; yb_q <= y0;
          end else begin
            xa_q <= x0; ya_q <= y0; xb_q <= x1; yb_q <= y1;
          end
          cx0_q <= cx0; cy0_q <= cy0; cx1_q <= cx1; cy1_q <= cy1;
          pat_q <= pattern;
          x     <= x0;
          y     <= y0;
        end
      end
      INIT_0: begin
        dx_q    <= xdiff_c[W1-1] ? -xdiff_c : xdiff_c;
        dy_q    <= W1'(ya_q) - W1'(yb_q);
        x_dec_q <= (xb_q < xa_q);
        x       <= xa_q;
        y       <= ya_q;
      end
      INIT_1: err_q <= dx_q + dy_q;
      DRAW: begin
        if (step_en_c) begin
          err_q <= err_next_c;
          if (x_step_c) x <= x_dec_q ? x - CORDW'(1) : x + CORDW'(1);
          if (y_step_c) y <= y + CORDW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_stream.sv
// Directed bench for line_stream: pixel order, clipping, dashes, backpressure,
// early exit, reset abort and back-to-back starts.
module tb_line_stream;

  localparam int CORDW = 16;
  localparam int PATW  = 8;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic signed [CORDW-1:0] x0, y0, x1, y1, cx0, cy0, cx1, cy1;
  logic [PATW-1:0] pattern;
  logic signed [CORDW-1:0] x, y;
  logic out_valid, last, busy, done;

  line_stream #(.CORDW(CORDW), .PATW(PATW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .cx0(cx0), .cy0(cy0), .cx1(cx1), .cy1(cy1),
    .pattern(pattern), .out_ready(out_ready),
    .x(x), .y(y), .out_valid(out_valid), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int px_q[$];
  int py_q[$];
  bit lst_q[$];
  int done_cnt, first_cyc, done_cyc, last_cyc, extra_valid;
  bit timed_out;

  // Called at a negedge; start is sampled on the following posedge
  task automatic start_line(input int ax0, ay0, ax1, ay1, input int wx0, wy0, wx1, wy1,
                            input logic [PATW-1:0] pat);
    x0 = CORDW'(ax0); y0 = CORDW'(ay0); x1 = CORDW'(ax1); y1 = CORDW'(ay1);
    cx0 = CORDW'(wx0); cy0 = CORDW'(wy0); cx1 = CORDW'(wx1); cy1 = CORDW'(wy1);
    pattern = pat;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input int max_cyc, input bit watch);
    px_q.delete(); py_q.delete(); lst_q.delete();
    done_cnt = 0; first_cyc = -1; done_cyc = -1; last_cyc = -1; extra_valid = 0;
    timed_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = c;
        px_q.push_back(int'(x)); py_q.push_back(int'(y)); lst_q.push_back(last);
        if (last) last_cyc = c;
      end
      if (done) begin
        done_cnt++; done_cyc = c; timed_out = 1'b0;
        break;
      end
    end
    if (watch) begin
      repeat (3) begin
        @(negedge clk);
        if (done) done_cnt++;
        if (out_valid) extra_valid++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; pattern = '1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; cx0 = '0; cy0 = '0; cx1 = '0; cy1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, out_valid, done, last} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: busy/valid/done/last=%b expected 0000", {busy, out_valid, done, last});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int ex[5] = '{0, 1, 2, 3, 4};
    int ey[5] = '{0, 0, 1, 1, 2};
    start_line(0, 0, 4, 2, 0, 0, 15, 15, 8'hFF);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_init: busy=%b out_valid=%b expected 1 0", busy, out_valid);
    end
    collect(40, 1'b1);
    checks++;
    if (timed_out || px_q.size() != 5) begin
      errors++; $display("FAIL basic_count: pixels=%0d timeout=%0d expected 5 0", px_q.size(), timed_out);
    end
    for (int i = 0; i < 5 && i < px_q.size(); i++) begin
      checks++;
      if (px_q[i] !== ex[i] || py_q[i] !== ey[i] || lst_q[i] !== (i == 4)) begin
        errors++; $display("FAIL basic_pixel%0d: got (%0d,%0d) last=%0d expected (%0d,%0d) last=%0d",
                           i, px_q[i], py_q[i], lst_q[i], ex[i], ey[i], (i == 4));
      end
    end
    checks++;
    if (first_cyc !== 1 || last_cyc !== 5 || done_cyc !== 6) begin
      errors++; $display("FAIL basic_timing: first=%0d last=%0d done=%0d expected 1 5 6", first_cyc, last_cyc, done_cyc);
    end
    checks++;
    if (done_cnt !== 1 || extra_valid !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done: done_cnt=%0d extra=%0d busy=%b expected 1 0 0", done_cnt, extra_valid, busy);
    end
  endtask

  task automatic test_reversed_diag();
    start_line(5, 5, 0, 0, 0, 0, 15, 15, 8'hFF);
    checks++;
    if (x !== 16'sd5 || y !== 16'sd5) begin
      errors++; $display("FAIL diag_load: x=%0d y=%0d expected 5 5", x, y);
    end
    collect(40, 1'b0);
    checks++;
    if (timed_out || px_q.size() != 6) begin
      errors++; $display("FAIL diag_count: pixels=%0d timeout=%0d expected 6 0", px_q.size(), timed_out);
    end
    for (int i = 0; i < 6 && i < px_q.size(); i++) begin
      checks++;
      if (px_q[i] !== i || py_q[i] !== i || lst_q[i] !== (i == 5)) begin
        errors++; $display("FAIL diag_pixel%0d: got (%0d,%0d) last=%0d expected (%0d,%0d) last=%0d",
                           i, px_q[i], py_q[i], lst_q[i], i, i, (i == 5));
      end
    end
  endtask

  task automatic test_pattern();
    start_line(0, 3, 7, 3, 0, 0, 15, 15, 8'b1010_1010);
    collect(40, 1'b0);
    checks++;
    if (timed_out || px_q.size() != 4) begin
      errors++; $display("FAIL pattern_count: pixels=%0d timeout=%0d expected 4 0", px_q.size(), timed_out);
    end
    for (int i = 0; i < 4 && i < px_q.size(); i++) begin
      checks++;
      if (px_q[i] !== 2 * i + 1 || py_q[i] !== 3 || lst_q[i] !== (i == 3)) begin
        errors++; $display("FAIL pattern_pixel%0d: got (%0d,%0d) last=%0d expected (%0d,3) last=%0d",
                           i, px_q[i], py_q[i], lst_q[i], 2 * i + 1, (i == 3));
      end
    end
  endtask

  task automatic test_early_exit();
    int nlast;
    start_line(0, 0, 0, 9, 0, 0, 15, 4, 8'hFF);
    collect(40, 1'b1);
    nlast = 0;
    foreach (lst_q[i]) if (lst_q[i]) nlast++;
    checks++;
    if (timed_out || px_q.size() != 5 || nlast != 0) begin
      errors++; $display("FAIL early_count: pixels=%0d lasts=%0d timeout=%0d expected 5 0 0", px_q.size(), nlast, timed_out);
    end
    for (int i = 0; i < 5 && i < px_q.size(); i++) begin
      checks++;
      if (px_q[i] !== 0 || py_q[i] !== i) begin
        errors++; $display("FAIL early_pixel%0d: got (%0d,%0d) expected (0,%0d)", i, px_q[i], py_q[i], i);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 7) begin
      errors++; $display("FAIL early_done: done_cnt=%0d done_cyc=%0d expected 1 7", done_cnt, done_cyc);
    end
  endtask

  task automatic test_backpressure();
    int stall_cnt = 0;
    bit got_done = 1'b0;
    px_q.delete(); py_q.delete();
    start_line(0, 0, 3, 0, 0, 0, 15, 15, 8'hFF);
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge clk);
      if (out_valid && x == 16'sd1 && stall_cnt < 3) begin
        if (stall_cnt > 0) begin
          checks++;
          if (x !== 16'sd1 || y !== 16'sd0 || last !== 1'b0) begin
            errors++; $display("FAIL stall_hold%0d: got (%0d,%0d) last=%b expected (1,0) last=0", stall_cnt, x, y, last);
          end
        end
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        px_q.push_back(int'(x)); py_q.push_back(int'(y));
      end
      if (done) got_done = 1'b1;
    end
    out_ready = 1'b1;
    checks++;
    if (!got_done || stall_cnt != 3 || px_q.size() != 4) begin
      errors++; $display("FAIL stall_count: done=%0d stalls=%0d pixels=%0d expected 1 3 4", got_done, stall_cnt, px_q.size());
    end
    for (int i = 0; i < 4 && i < px_q.size(); i++) begin
      checks++;
      if (px_q[i] !== i || py_q[i] !== 0) begin
        errors++; $display("FAIL stall_pixel%0d: got (%0d,%0d) expected (%0d,0)", i, px_q[i], py_q[i], i);
      end
    end
  endtask

  task automatic test_octants();
    // Anti-diagonal with x stepping down
    start_line(2, 0, 0, 2, 0, 0, 15, 15, 8'hFF);
    collect(40, 1'b0);
    checks++;
    if (timed_out || px_q.size() != 3 || px_q[0] !== 2 || px_q[1] !== 1 || py_q[1] !== 1 ||
        px_q[2] !== 0 || py_q[2] !== 2) begin
      errors++; $display("FAIL antidiag: pixels=%0d first=(%0d,%0d) expected 3 pixels (2,0),(1,1),(0,2)",
                         px_q.size(), (px_q.size() > 0) ? px_q[0] : -99, (py_q.size() > 0) ? py_q[0] : -99);
    end
    // Single point
    start_line(7, 7, 7, 7, 0, 0, 15, 15, 8'hFF);
    collect(40, 1'b0);
    checks++;
    if (timed_out || px_q.size() != 1 || px_q[0] !== 7 || py_q[0] !== 7 || lst_q[0] !== 1'b1) begin
      errors++; $display("FAIL single_point: pixels=%0d timeout=%0d expected one (7,7) with last", px_q.size(), timed_out);
    end
    // Negative coordinates, horizontal
    start_line(-2, -1, 1, -1, -4, -4, 4, 4, 8'hFF);
    collect(40, 1'b0);
    checks++;
    if (timed_out || px_q.size() != 4 || px_q[0] !== -2 || py_q[0] !== -1 || px_q[3] !== 1 || lst_q[3] !== 1'b1) begin
      errors++; $display("FAIL negative_line: pixels=%0d first_x=%0d expected 4 pixels from (-2,-1) to (1,-1)",
                         px_q.size(), (px_q.size() > 0) ? px_q[0] : -99);
    end
  endtask

  task automatic test_empty_window();
    start_line(0, 0, 3, 3, 5, 0, 2, 15, 8'hFF);
    collect(60, 1'b1);
    checks++;
    if (timed_out || px_q.size() != 0 || done_cnt !== 1 || extra_valid !== 0) begin
      errors++; $display("FAIL empty_window: pixels=%0d done_cnt=%0d timeout=%0d expected 0 1 0", px_q.size(), done_cnt, timed_out);
    end
  endtask

  task automatic test_reset_abort();
    start_line(0, 0, 9, 0, 0, 0, 15, 15, 8'hFF);
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || x !== 16'sd1) begin
      errors++; $display("FAIL abort_setup: out_valid=%b x=%0d expected 1 1", out_valid, x);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_state: busy=%b out_valid=%b done=%b expected 0 0 0", busy, out_valid, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL abort_nodone: done=%b expected 0", done);
    end
    start_line(2, 2, 4, 2, 0, 0, 15, 15, 8'hFF);
    collect(40, 1'b0);
    checks++;
    if (timed_out || px_q.size() != 3 || px_q[0] !== 2 || py_q[0] !== 2 || px_q[2] !== 4 || first_cyc !== 1) begin
      errors++; $display("FAIL abort_restart: pixels=%0d first_cyc=%0d expected 3 pixels from (2,2), first_cyc 1",
                         px_q.size(), first_cyc);
    end
  endtask

  task automatic test_back_to_back();
    start_line(0, 0, 2, 0, 0, 0, 15, 15, 8'hFF);
    // Start while busy must be ignored
    x0 = 16'sd9; y0 = 16'sd9; x1 = 16'sd9; y1 = 16'sd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(40, 1'b0);
    checks++;
    if (timed_out || px_q.size() != 3 || px_q[0] !== 0 || px_q[2] !== 2 || py_q[2] !== 0) begin
      errors++; $display("FAIL busy_start_ignored: pixels=%0d timeout=%0d expected (0,0)..(2,0)", px_q.size(), timed_out);
    end
    // Start in the same cycle done is high
    start_line(3, 1, 3, 3, 0, 0, 15, 15, 8'hFF);
    collect(40, 1'b0);
    checks++;
    if (timed_out || px_q.size() != 3 || px_q[0] !== 3 || py_q[0] !== 1 || py_q[2] !== 3 || first_cyc !== 1) begin
      errors++; $display("FAIL start_on_done: pixels=%0d first_cyc=%0d expected 3 pixels (3,1)..(3,3), first_cyc 1",
                         px_q.size(), first_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reversed_diag();
    test_pattern();
    test_early_exit();
    test_backpressure();
    test_octants();
    test_empty_window();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_stream.md
LINE_STREAM -- requirements
Module: line_stream

Interface
REQ-001 The block SHALL have a parameter CORDW, default 16, giving the signed coordinate width in bits.
REQ-002 The block SHALL have a parameter PATW, default 8, giving the dash-pattern length in pixels; PATW SHALL be a power of two and at least 1.
REQ-003 clk  in  1  clock; all logic SHALL be sampled on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request a line; sampled only in IDLE.
REQ-006 x0, y0, x1, y1  in  CORDW signed each  line endpoints.
REQ-007 cx0, cy0, cx1, cy1  in  CORDW signed each  inclusive clip window; sampled with start.
REQ-008 pattern  in  PATW  dash mask; bit i set means pattern step i is drawn; sampled with start.
REQ-009 out_ready  in  1  downstream accepts the current pixel.
REQ-010 x, y  out  CORDW signed each  current pixel coordinate.
REQ-011 out_valid  out  1  x and y hold a pixel to emit.
REQ-012 last  out  1  the current pixel is the line end coordinate.
REQ-013 busy  out  1  a line is in progress (INIT_0 through DRAW).
REQ-014 done  out  1  one-cycle pulse when a line completes.

Function
REQ-015 Drawing SHALL use Bresenham stepping and cover all octants, including horizontal, vertical and single-point lines.
REQ-016 Endpoints SHALL be reordered so that y never decreases during drawing; x SHALL step by +1 or -1 according to direction.
REQ-017 dx SHALL be abs(xb-xa) and dy SHALL be -abs(yb-ya), with dx, dy and err held as CORDW+1 signed values.
REQ-018 The 2*err comparisons SHALL be evaluated at CORDW+2 bits so that no overflow occurs at full-scale coordinates.
REQ-019 The state machine SHALL have states IDLE, INIT_0, INIT_1 and DRAW.
REQ-020 IDLE SHALL move to INIT_0 on start; INIT_0 SHALL move to INIT_1 after one cycle; INIT_1 SHALL move to DRAW after one cycle.
REQ-021 DRAW SHALL move back to IDLE after the end coordinate has been processed.
REQ-022 The first pixel SHALL be presented in DRAW exactly 3 cycles after start is sampled.
REQ-023 Each pixel in DRAW SHALL be "visible" when cx0<=x<=cx1, cy0<=y<=cy1 and pattern[idx] is set.
REQ-024 out_valid SHALL equal (state==DRAW and the current pixel is visible).
REQ-025 A visible pixel SHALL advance only when out_valid and out_ready are both high; while out_ready is low, x, y, last and the internal state SHALL hold.
REQ-026 An invisible pixel SHALL advance one step per cycle without asserting out_valid.
REQ-027 idx SHALL start at 0 and increment modulo PATW on every pixel step, whether the pixel is visible or not.
REQ-028 If y > cy1 in DRAW, the line SHALL terminate immediately (early exit) with a done pulse and no further pixels.
REQ-029 If the end pixel is invisible, done SHALL still pulse once after it is stepped past, and last SHALL never be seen with out_valid for that line.
REQ-030 done SHALL be high for exactly the one cycle after the DRAW to IDLE transition; busy SHALL fall on that same edge.
REQ-031 A start asserted while busy SHALL be ignored; a start in the cycle done is high SHALL be accepted.
REQ-032 x and y SHALL load x0 and y0 when start is accepted, so that no spurious coordinates appear before DRAW.
REQ-033 A clip window with cx0>cx1 or cy0>cy1 SHALL produce no pixels and a single done pulse.

Reset
REQ-034 rst SHALL force state to IDLE and clear busy, out_valid, done, last and idx to 0, overriding any other update in the same cycle.
REQ-035 x and y SHALL have no reset requirement.
REQ-036 rst mid-line SHALL abort the line with no done pulse.

Structure
REQ-037 No shared package SHALL be used; state encodings SHALL be local constants, and CORDW SHALL be passed down from the parent.
REQ-038 The visibility test SHALL be a single combinational sub-module, clip_test, which compares a point against the window.

Verification
REQ-039 Line (0,0)-(4,2), window (0,0)-(15,15), pattern 0xFF, out_ready=1 SHALL emit (0,0),(1,0),(2,1),(3,1),(4,2) on consecutive cycles, with last on (4,2) and done one cycle later.
REQ-040 Line (5,5)-(0,0) SHALL emit (0,0) through (5,5) along the diagonal in 6 pixels.
REQ-041 Line (0,3)-(7,3) with pattern 0b10101010 (PATW=8) SHALL emit x=1,3,5,7 only, with last on (7,3).
REQ-042 Line (0,0)-(0,9), window y 0..4 SHALL emit y=0..4, exit early, and pulse done once with no last.
REQ-043 Line (0,0)-(3,0) with out_ready low for 3 cycles at (1,0) SHALL hold (1,0) stable and lose or duplicate no pixels.
REQ-044 rst asserted on the second DRAW cycle SHALL force busy=0 and out_valid=0 on the next cycle with no done; a start 1 cycle later SHALL begin a fresh line.
